// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state, and the
// memory arbiter's grant state plus its default tuning values.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_DSTREAK = 4;
    localparam int ARB_TIMEOUT     = 255;

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog for the arbiter's busy states: counts cycles spent waiting on
// the RAM and flags expiry once the configured limit is reached.
module arb_timeout_counter
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = ARB_TIMEOUT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WIDTH-1:0] tcnt;

    assign expire = (tcnt == WIDTH'(LIMIT));

    // Busy-cycle count; clear wins, and the count parks at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tcnt <= '0;
        end else if (clear) begin
            tcnt <= '0;
        end else if (enable && !expire) begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Data has priority, a streak limit guarantees fetch progress, and a
// watchdog abandons transfers when the RAM never answers.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = ARB_MAX_DSTREAK,
    parameter int TIMEOUT     = ARB_TIMEOUT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    arb_state_t          state, state_next;
    ramstate_t           rs;
    logic [STREAK_W-1:0] streak;
    logic                data_req, req_held;
    logic                grant_d, grant_i, finish, abort, fail;
    logic                expire;

    assign rs       = ramstate_t'(ramstate);
    assign data_req = dREN | dWEN;
    assign iwait    = iREN & ~ihit;
    assign dwait    = data_req & ~dhit;

    arb_timeout_counter #(
        .WIDTH (8),
        .LIMIT (TIMEOUT)
    ) u_tcnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (state_next == IDLE),
        .enable (state_next != IDLE),
        .expire (expire)
    );

    // Next-state and grant/complete/abort decisions.
    // While a hit is being presented the requester still holds its old
    // request, so no grant is made in that cycle.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        fail       = 1'b0;
        req_held   = 1'b0;
        case (state)
            IDLE: begin
                if (!(ihit || dhit)) begin
                    if (data_req && ((streak < STREAK_MAX) || !iREN)) begin
                        grant_d    = 1'b1;
                        state_next = DBUSY;
                    end else if (iREN) begin
                        grant_i    = 1'b1;
                        state_next = IBUSY;
                    end
                end
            end
            IBUSY, DBUSY: begin
                req_held = (state == IBUSY) ? iREN : data_req;
                if (!req_held) begin
                    abort = 1'b1;
                end else if (rs == ERROR) begin
                    fail = 1'b1;
                end else if (rs == ACCESS) begin
                    finish = 1'b1;
                end else if (expire) begin
                    fail = 1'b1;
                end
                if (abort || fail || finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, captured RAM request, streak, hit pulses and load registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            streak   <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            arb_err  <= 1'b0;
        end else begin
            state <= state_next;
            ihit  <= 1'b0;
            dhit  <= 1'b0;
            if (grant_d) begin
                ramaddr  <= daddr;
                ramstore <= dstore;
                ramWEN   <= dWEN;
                ramREN   <= ~dWEN;
                streak   <= iREN ? ((streak == STREAK_MAX) ? streak : streak + 1'b1) : '0;
            end
            if (grant_i) begin
                ramaddr <= iaddr;
                ramREN  <= 1'b1;
                ramWEN  <= 1'b0;
                streak  <= '0;
            end
            if (finish) begin
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
                if (state == IBUSY) begin
                    ihit  <= 1'b1;
                    iload <= ramload;
                end else begin
                    dhit <= 1'b1;
                    if (!ramWEN) begin
                        dload <= ramload;
                    end
                end
            end
            if (abort || fail) begin
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
            end
            if (fail) begin
                arb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: randomized requesters against a
// transaction-level model (priority/streak rule, RAM contents), followed by
// directed scenarios for timeout, error, reset and abort.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int MAXD = 4;
    localparam int TMO  = 255;

    logic        CLK, nRST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    memory_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iwait(iwait),
        .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .arb_err(arb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_strobe(input string tag, input int limit);
        int n = 0;
        while (!(ramREN || ramWEN) && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, ramREN | ramWEN, 1);
    endtask

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
    endfunction

    initial begin
        logic        g_act, g_d, g_we, exp_hit, exp_ih, exp_dh, pi, pd, pwe, s, prev;
        logic        new_d;
        logic [31:0] g_addr, g_data, rd_exp, pia, pda, pds, dload_before;
        int          lat, streak_m, iw, dw, iw_max, dw_max, n_d, n_i, g, n, hits, kind;

        g_act = 0; g_d = 0; g_we = 0; exp_hit = 0; pi = 0; pd = 0; pwe = 0;
        g_addr = 0; g_data = 0; rd_exp = 0; pia = 0; pda = 0; pds = 0;
        lat = 0; streak_m = 0; iw = 0; dw = 0; iw_max = 0; dw_max = 0; n_d = 0; n_i = 0;

        nRST = 0; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = FREE;
        repeat (2) tick();
        check_eq("rst_flags", {27'd0, ramREN, ramWEN, ihit, dhit, arb_err}, 0);
        check_eq("rst_ramaddr", ramaddr, 0);
        check_eq("rst_ramstore", ramstore, 0);
        check_eq("rst_iload", iload, 0);
        check_eq("rst_dload", dload, 0);
        nRST = 1;
        tick();

        // ---------------- randomized phase ----------------
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            exp_ih = exp_hit && !g_d;
            exp_dh = exp_hit && g_d;
            check_eq("r_ihit", ihit, exp_ih);
            check_eq("r_dhit", dhit, exp_dh);
            check_eq("r_iwait", iwait, iREN && !exp_ih);
            check_eq("r_dwait", dwait, (dREN || dWEN) && !exp_dh);
            iw = (iREN && !exp_ih) ? iw + 1 : 0;
            dw = ((dREN || dWEN) && !exp_dh) ? dw + 1 : 0;
            if (iw > iw_max) iw_max = iw;
            if (dw > dw_max) dw_max = dw;

            if (exp_hit) begin
                check_eq("r_strobe_drop", {30'd0, ramREN, ramWEN}, 0);
                if (!g_d) check_eq("r_iload", iload, rd_exp);
                else if (!g_we) check_eq("r_dload", dload, rd_exp);
                exp_hit = 0;
                g_act = 0;
            end else if (!g_act && (ramREN || ramWEN)) begin
                check_eq("r_grant_pending", pi || pd, 1);
                if (pd && (streak_m < MAXD || !pi)) begin
                    g_d = 1; g_we = pwe; g_addr = pda; g_data = pds;
                    streak_m = pi ? ((streak_m < MAXD) ? streak_m + 1 : MAXD) : 0;
                    n_d++;
                end else begin
                    g_d = 0; g_we = 0; g_addr = pia; g_data = 0;
                    streak_m = 0;
                    n_i++;
                end
                check_eq("r_grant_kind", {30'd0, ramREN, ramWEN}, g_we ? 32'd1 : 32'd2);
                check_eq("r_grant_addr", ramaddr, g_addr);
                if (g_we) check_eq("r_grant_store", ramstore, g_data);
                g_act = 1;
                lat = $urandom_range(0, 3);
            end else if (g_act) begin
                check_eq("r_hold_addr", ramaddr, g_addr);
                check_eq("r_hold_kind", {30'd0, ramREN, ramWEN}, g_we ? 32'd1 : 32'd2);
            end

            // RAM behaviour
            if (g_act) begin
                if (lat > 0) begin
                    ramstate = BUSY; lat--; ramload = $urandom;
                end else begin
                    ramstate = ACCESS; exp_hit = 1;
                    if (g_we) begin
                        mem[g_addr] = g_data; ramload = $urandom;
                    end else begin
                        rd_exp = mem_rd(g_addr); ramload = rd_exp;
                    end
                end
            end else begin
                ramstate = FREE; ramload = $urandom;
            end

            // fetch requester
            if (iREN && ihit) begin
                iREN = ($urandom_range(0, 1) == 1);
                iaddr = {26'd0, 4'($urandom), 2'b00};
            end else if (!iREN && $urandom_range(0, 2) == 0) begin
                iREN = 1;
                iaddr = {26'd0, 4'($urandom), 2'b00};
            end

            // data requester
            new_d = 0;
            if ((dREN || dWEN) && dhit) begin
                new_d = ($urandom_range(0, 1) == 1);
                if (!new_d) begin dREN = 0; dWEN = 0; end
            end else if (!(dREN || dWEN)) begin
                new_d = ($urandom_range(0, 2) == 0);
            end
            if (new_d) begin
                kind = $urandom_range(0, 2);
                dREN = (kind != 1);
                dWEN = (kind != 0);
                daddr = {26'd0, 4'($urandom), 2'b00};
                dstore = $urandom;
            end

            pi = iREN; pd = dREN || dWEN; pwe = dWEN;
            pia = iaddr; pda = daddr; pds = dstore;
        end
        check_eq("r_fetch_wait_bound", iw_max <= 60, 1);
        check_eq("r_data_wait_bound", dw_max <= 60, 1);
        check_eq("r_both_served", (n_d > 10) && (n_i > 10), 1);
        check_eq("r_err_clear", arb_err, 0);
        iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
        repeat (3) tick();
        check_eq("r_quiesce", {30'd0, ramREN, ramWEN}, 0);

        // ---------------- 1: basic fetch ----------------
        iREN = 1; iaddr = 32'h40;
        wait_strobe("t1_grant", 4);
        check_eq("t1_kind", {30'd0, ramREN, ramWEN}, 2);
        check_eq("t1_addr", ramaddr, 32'h40);
        check_eq("t1_iwait", iwait, 1);
        ramstate = BUSY;
        tick();
        check_eq("t1_busy_ihit", ihit, 0);
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        tick();
        check_eq("t1_ihit", ihit, 1);
        check_eq("t1_iload", iload, 32'hDEADBEEF);
        check_eq("t1_iwait_hit", iwait, 0);
        check_eq("t1_strobe_drop", ramREN, 0);
        iREN = 0; ramstate = FREE; ramload = 0;
        tick();
        check_eq("t1_ihit_once", ihit, 0);
        check_eq("t1_iload_hold", iload, 32'hDEADBEEF);

        // ---------------- 2: data write beats fetch ----------------
        dload_before = dload;
        dWEN = 1; daddr = 32'h100; dstore = 32'h1234; iREN = 1; iaddr = 32'h80;
        wait_strobe("t2_grant", 4);
        check_eq("t2_kind", {30'd0, ramREN, ramWEN}, 1);
        check_eq("t2_addr", ramaddr, 32'h100);
        check_eq("t2_store", ramstore, 32'h1234);
        daddr = 32'h999; dstore = 32'h0; ramstate = BUSY;
        tick();
        check_eq("t2_addr_stable", ramaddr, 32'h100);
        check_eq("t2_store_stable", ramstore, 32'h1234);
        ramstate = ACCESS; ramload = 32'h7777_7777;
        tick();
        check_eq("t2_dhit", dhit, 1);
        check_eq("t2_no_ihit", ihit, 0);
        check_eq("t2_dload_kept", dload, dload_before);
        dWEN = 0; ramstate = FREE;
        wait_strobe("t2_fetch_grant", 6);
        check_eq("t2_fetch_kind", {30'd0, ramREN, ramWEN}, 2);
        check_eq("t2_fetch_addr", ramaddr, 32'h80);
        ramstate = ACCESS; ramload = 32'hCAFE0080;
        tick();
        check_eq("t2_ihit", ihit, 1);
        check_eq("t2_iload", iload, 32'hCAFE0080);
        iREN = 0; ramstate = FREE;
        tick();

        // ---------------- 3: streak limit ----------------
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
        g = 0; prev = 0;
        for (int c = 0; c < 200 && g < 10; c++) begin
            tick();
            s = ramREN | ramWEN;
            if (s && !prev) begin
                check_eq($sformatf("t3_grant%0d", g), ramaddr, ((g % 5) == 4) ? 32'h200 : 32'h300);
                g++;
            end
            prev = s;
            ramstate = s ? ACCESS : FREE;
            ramload = $urandom;
        end
        check_eq("t3_grant_count", g, 10);
        iREN = 0; dREN = 0;
        tick();
        ramstate = FREE;
        repeat (3) tick();

        // ---------------- 4: timeout ----------------
        check_eq("t4_err_before", arb_err, 0);
        iREN = 1; iaddr = 32'h44; ramstate = BUSY;
        wait_strobe("t4_grant", 4);
        n = 0; hits = 0;
        while ((ramREN || ramWEN) && n < 400) begin
            n++;
            hits += int'(ihit | dhit);
            tick();
            if (!(ramREN || ramWEN)) iREN = 0;
        end
        check_eq("t4_busy_cycles", n, TMO);
        check_eq("t4_no_hit", hits + int'(ihit | dhit), 0);
        check_eq("t4_err", arb_err, 1);
        iREN = 0; ramstate = FREE;
        tick();
        dREN = 1; daddr = 32'h48;
        wait_strobe("t4_after_grant", 4);
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        tick();
        check_eq("t4_after_dhit", dhit, 1);
        check_eq("t4_after_dload", dload, 32'h0BADF00D);
        check_eq("t4_err_sticky", arb_err, 1);
        dREN = 0; ramstate = FREE;
        tick();

        // ---------------- 5: async reset mid-DBUSY ----------------
        dREN = 1; daddr = 32'h500; ramstate = BUSY;
        wait_strobe("t5_grant", 4);
        tick();
        #2;
        nRST = 0; dREN = 0; iREN = 1; iaddr = 32'h600;
        #1;
        check_eq("t5_rst_flags", {27'd0, ramREN, ramWEN, ihit, dhit, arb_err}, 0);
        check_eq("t5_rst_ramaddr", ramaddr, 0);
        check_eq("t5_rst_dload", dload, 0);
        check_eq("t5_rst_iload", iload, 0);
        tick();
        nRST = 1; ramstate = FREE;
        tick();
        check_eq("t5_fetch_kind", {30'd0, ramREN, ramWEN}, 2);
        check_eq("t5_fetch_addr", ramaddr, 32'h600);
        ramstate = ACCESS; ramload = 32'h0060_0600;
        tick();
        check_eq("t5_ihit", ihit, 1);
        check_eq("t5_iload", iload, 32'h0060_0600);
        iREN = 0; ramstate = FREE;
        tick();

        // ---------------- 6: data request dropped while busy ----------------
        dREN = 1; daddr = 32'h700; ramstate = BUSY;
        wait_strobe("t6_grant", 4);
        tick();
        dREN = 0;
        tick();
        check_eq("t6_strobe_drop", {30'd0, ramREN, ramWEN}, 0);
        check_eq("t6_no_dhit", dhit, 0);
        ramstate = FREE;
        tick();
        check_eq("t6_no_dhit_later", dhit, 0);
        iREN = 1; iaddr = 32'h704;
        wait_strobe("t6_next_grant", 4);
        check_eq("t6_next_addr", ramaddr, 32'h704);
        ramstate = ACCESS; ramload = 32'h1111_0704;
        tick();
        check_eq("t6_next_ihit", ihit, 1);
        iREN = 0; ramstate = FREE;
        tick();

        // ---------------- 7: RAM error ----------------
        check_eq("t7_err_before", arb_err, 0);
        iREN = 1; iaddr = 32'h800;
        wait_strobe("t7_grant", 4);
        ramstate = ERROR;
        tick();
        check_eq("t7_strobe_drop", {30'd0, ramREN, ramWEN}, 0);
        check_eq("t7_no_ihit", ihit, 0);
        check_eq("t7_err", arb_err, 1);
        iREN = 0; ramstate = FREE;
        tick();
        check_eq("t7_no_ihit_later", ihit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
